// File: rtl/int_ctrl.sv
// int_ctrl: eight-line priority interrupt controller.
// Lines 7:2 are synchronized external requests; lines 1:0 are reserved for
// internal exceptions and only track in-service state driven by the control unit.
// Bit 0 is the highest priority. Outputs are decoded from registers only.
// Build option: define INT_EDGE_EN for rising-edge request capture; when it is
// left undefined, pending bits follow the synchronized line level.
module int_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq_in,
    input  logic [7:0] s_calli,
    input  logic [7:0] s_reti,
    input  logic       we_mask,
    input  logic [7:0] mask_in,
    output logic [7:0] min_bit_s,
    output logic [7:0] min_bit_a,
    output logic       int_busy
);

    // Synchronizer chain for lines 7:2; element 0 is the first flop.
    logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
    logic [5:0]                  irq_sync;
    logic [5:0]                  pend_q, pend_d;
    logic [7:0]                  isr_q, isr_d;
    logic [7:0]                  mask_q, mask_d;
    logic [7:0]                  cand;
    logic                        unused_irq;

    assign irq_sync   = sync_q[SYNC_STAGES-1];
    assign unused_irq = ^irq_in[1:0];

`ifdef INT_EDGE_EN
    // The chain restarts from zero after reset, so the first edges seen out of
    // it cannot be trusted: a line held high through reset would look like a
    // fresh rise. Edge capture stays disarmed until the chain and the history
    // flop both hold genuinely sampled values.
    localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

    logic [5:0] hist_q, hist_d;
    logic [2:0] warm_q, warm_d;
    logic [5:0] rise;

    // Edge mode: latch one pending bit per synchronized rise; a new rise beats a call.
    always_comb begin
        hist_d = irq_sync;
        warm_d = (warm_q == WARM_MAX) ? warm_q : warm_q + 3'd1;
        rise   = irq_sync & ~hist_q & {6{warm_q == WARM_MAX}};
        pend_d = (pend_q & ~s_calli[7:2]) | rise;
    end

    // Edge history and warm-up counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            warm_q <= '0;
        end else begin
            hist_q <= hist_d;
            warm_q <= warm_d;
        end
    end
`else
    // Level mode: pending mirrors the synchronized line, except while the line is
    // being entered or is already in service, so a held line re-pends right after return.
    always_comb begin
        pend_d = irq_sync & ~s_calli[7:2] & ~isr_q[7:2];
    end
`endif

    // Next state for synchronizer, in-service and mask; calls are applied after
    // returns so a simultaneous call and return of one bit leaves it set.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_in[7:2]};
        isr_d  = (isr_q & ~s_reti) | s_calli;
        mask_d = we_mask ? mask_in : mask_q;
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            pend_q <= '0;
            isr_q  <= '0;
            mask_q <= '0;
        end else begin
            sync_q <= sync_d;
            pend_q <= pend_d;
            isr_q  <= isr_d;
            mask_q <= mask_d;
        end
    end

    // Priority decode: isolate the lowest set bit (v & -v) of the request and
    // in-service vectors. Lower-priority requests are still reported while a
    // higher one is in service; preemption is decided by the control unit.
    always_comb begin
        cand      = {pend_q, 2'b00} & ~mask_q & ~isr_q;
        min_bit_s = cand & (~cand + 8'd1);
        min_bit_a = isr_q & (~isr_q + 8'd1);
        int_busy  = |isr_q;
    end

endmodule
